// File: rtl/ram_arb.sv
// Two-port (CPU / debug) arbiter onto a single combinational-read RAM.
// Round-robin sharing, plus a debug lock that gives the debug port exclusive ownership.
module ram_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [2:0]    i_cpu_size,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic          o_cpu_rvalid,
    output logic [DW-1:0] o_cpu_rdata,

    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [2:0]    i_dbg_size,
    input  logic [DW-1:0] i_dbg_wdata,
    input  logic          i_dbg_lock,
    output logic          o_dbg_gnt,
    output logic          o_dbg_rvalid,
    output logic [DW-1:0] o_dbg_rdata,

    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [2:0]    o_ram_size,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata,

    output logic          o_locked
);

    typedef enum logic [1:0] {
        SHARED    = 2'd0,
        LOCK_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t state;
    logic   prio_dbg;   // 1: debug wins the next tie
    logic   cpu_gnt;
    logic   dbg_gnt;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!i_rst) begin
            if (state == SHARED) begin
                if (i_cpu_req && (!i_dbg_req || !prio_dbg)) begin
                    cpu_gnt = 1'b1;
                end else if (i_dbg_req) begin
                    dbg_gnt = 1'b1;
                end
            end else begin
                dbg_gnt = i_dbg_req;
            end
        end
    end

    assign o_cpu_gnt   = cpu_gnt;
    assign o_dbg_gnt   = dbg_gnt;

    // With no grant the RAM port idles on the CPU inputs with we held low.
    assign o_ram_addr  = dbg_gnt ? i_dbg_addr  : i_cpu_addr;
    assign o_ram_size  = dbg_gnt ? i_dbg_size  : i_cpu_size;
    assign o_ram_wdata = dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
    assign o_ram_we    = (cpu_gnt & i_cpu_we) | (dbg_gnt & i_dbg_we);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= SHARED;
            prio_dbg <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            case (state)
                SHARED: begin
                    if (cpu_gnt) begin
                        prio_dbg <= 1'b1;
                    end else if (dbg_gnt) begin
                        prio_dbg <= 1'b0;
                    end
                    if (i_dbg_lock) begin
                        state <= LOCK_WAIT;
                    end
                end
                LOCK_WAIT: begin
                    if (!i_dbg_lock) begin
                        state    <= SHARED;
                        prio_dbg <= 1'b0;
                    end else begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!i_dbg_lock) begin
                        state    <= SHARED;
                        prio_dbg <= 1'b0;
                        o_locked <= 1'b0;
                    end
                end
                default: begin
                    state    <= SHARED;
                    prio_dbg <= 1'b0;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

    // Read data is captured on the grant edge and presented for one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cpu_rvalid <= 1'b0;
            o_cpu_rdata  <= '0;
            o_dbg_rvalid <= 1'b0;
            o_dbg_rdata  <= '0;
        end else begin
            o_cpu_rvalid <= cpu_gnt & ~i_cpu_we;
            o_dbg_rvalid <= dbg_gnt & ~i_dbg_we;
            if (cpu_gnt && !i_cpu_we) begin
                o_cpu_rdata <= i_ram_rdata;
            end
            if (dbg_gnt && !i_dbg_we) begin
                o_dbg_rdata <= i_ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed stimulus pushes expected grants into a scoreboard;
// a negedge monitor checks grants, RAM port and read returns against it.
module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]  cpu_size = 3'd2;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [2:0]  dbg_size = 3'd2;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, locked;
    logic [2:0]  ram_size;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        bit          dbg;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } gnt_e_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rv_e_t;

    gnt_e_t gq[$];
    rv_e_t  cpu_rq[$];
    rv_e_t  dbg_rq[$];

    ram_arb #(.AW(32), .DW(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_size(cpu_size), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
        .i_dbg_size(dbg_size), .i_dbg_wdata(dbg_wdata), .i_dbg_lock(dbg_lock),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_size(ram_size),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
        .o_locked(locked)
    );

    // RAM contents: 0x10 holds 0xDEADBEEF, every other word is addr ^ 0xA5A50000.
    function automatic logic [31:0] ram_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign ram_rdata = ram_val(ram_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic exp_gnt(input bit d, input bit we, input logic [31:0] a,
                           input logic [31:0] wd);
        gnt_e_t e;
        e.cyc = cyc; e.dbg = d; e.we = we; e.addr = a; e.wdata = wd;
        e.rdata = ram_val(a);
        gq.push_back(e);
    endtask

    // Monitor: read returns first, then this cycle's grant (which may schedule a return).
    always @(negedge clk) begin
        if (!rst) begin
            bit     ex;
            rv_e_t  r;
            gnt_e_t g;

            ex = (cpu_rq.size() > 0) && (cpu_rq[0].cyc == cyc);
            if (ex || cpu_rvalid) begin
                chk("cpu_rvalid", {63'd0, cpu_rvalid}, {63'd0, ex});
                if (ex) begin
                    r = cpu_rq.pop_front();
                    chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, r.data});
                end
            end

            ex = (dbg_rq.size() > 0) && (dbg_rq[0].cyc == cyc);
            if (ex || dbg_rvalid) begin
                chk("dbg_rvalid", {63'd0, dbg_rvalid}, {63'd0, ex});
                if (ex) begin
                    r = dbg_rq.pop_front();
                    chk("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, r.data});
                end
            end

            if ((gq.size() > 0) && (gq[0].cyc == cyc)) begin
                g = gq.pop_front();
                chk("gnt_pair", {62'd0, cpu_gnt, dbg_gnt}, {62'd0, ~g.dbg, g.dbg});
                chk("ram_we", {63'd0, ram_we}, {63'd0, g.we});
                chk("ram_addr", {32'd0, ram_addr}, {32'd0, g.addr});
                if (g.we) begin
                    chk("ram_wdata", {32'd0, ram_wdata}, {32'd0, g.wdata});
                end else begin
                    r.cyc  = cyc + 1;
                    r.data = g.rdata;
                    if (g.dbg) dbg_rq.push_back(r);
                    else       cpu_rq.push_back(r);
                end
            end else if (cpu_gnt || dbg_gnt) begin
                chk("unexpected_gnt", {62'd0, cpu_gnt, dbg_gnt}, 64'd0);
            end
        end
    end

    initial begin
        // Reset with both ports requesting writes: nothing may be granted.
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b1; dbg_we = 1'b1;
        #2 rst = 1'b1;
        next_cyc();
        mid();
        chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("rst_dbg_gnt", {63'd0, dbg_gnt}, 64'd0);
        chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
        chk("rst_rvalids", {62'd0, cpu_rvalid, dbg_rvalid}, 64'd0);
        chk("rst_rdatas", {cpu_rdata, dbg_rdata}, 64'd0);
        chk("rst_locked", {63'd0, locked}, 64'd0);
        next_cyc();
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
        next_cyc();

        // Single CPU read of 0x10.
        cpu_req = 1'b1; cpu_addr = 32'h10;
        exp_gnt(1'b0, 1'b0, 32'h10, 32'h0);
        mid();
        next_cyc();
        cpu_req = 1'b0;
        mid();
        next_cyc();
        mid();
        chk("cpu_rvalid_drop", {63'd0, cpu_rvalid}, 64'd0);
        chk("cpu_rdata_hold", {32'd0, cpu_rdata}, 64'hDEADBEEF);
        next_cyc();

        // Debug write: one-cycle we, no read return.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
        exp_gnt(1'b1, 1'b1, 32'h40, 32'h12345678);
        mid();
        next_cyc();
        dbg_req = 1'b0; dbg_we = 1'b0;
        mid();
        chk("dbg_we_one_cycle", {63'd0, ram_we}, 64'd0);
        chk("dbg_write_no_rvalid", {63'd0, dbg_rvalid}, 64'd0);
        next_cyc();

        // Both ports read continuously: strict alternation starting with CPU.
        cpu_addr = 32'h100; dbg_addr = 32'h200;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_gnt(1'b0, 1'b0, 32'h100, 32'h0);
            else            exp_gnt(1'b1, 1'b0, 32'h200, 32'h0);
            mid();
            next_cyc();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        mid();
        next_cyc();

        // Lock requested alongside a CPU read: the CPU still wins that cycle.
        cpu_req = 1'b1; cpu_addr = 32'h300; dbg_lock = 1'b1;
        exp_gnt(1'b0, 1'b0, 32'h300, 32'h0);
        mid();
        chk("lock_req_not_locked", {63'd0, locked}, 64'd0);
        next_cyc();
        cpu_addr = 32'h304;
        mid();
        chk("lock_wait_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("lock_wait_locked", {63'd0, locked}, 64'd0);
        next_cyc();
        for (int i = 0; i < 10; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h55;
            exp_gnt(1'b1, 1'b1, 32'h20, 32'h55);
            mid();
            chk("locked_flag", {63'd0, locked}, 64'd1);
            chk("locked_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
            next_cyc();
        end
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
        mid();
        chk("unlock_cycle_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        next_cyc();
        dbg_req = 1'b1; dbg_addr = 32'h24;
        exp_gnt(1'b0, 1'b0, 32'h304, 32'h0);
        mid();
        chk("unlocked_flag", {63'd0, locked}, 64'd0);
        next_cyc();
        cpu_req = 1'b0;
        exp_gnt(1'b1, 1'b0, 32'h24, 32'h0);
        mid();
        next_cyc();
        dbg_req = 1'b0;
        mid();
        next_cyc();

        // A brief CPU write request while locked is never performed.
        dbg_lock = 1'b1;
        next_cyc();
        next_cyc();
        mid();
        chk("relock_flag", {63'd0, locked}, 64'd1);
        next_cyc();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hBAD;
        mid();
        chk("locked_brief_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("locked_brief_ram_we", {63'd0, ram_we}, 64'd0);
        next_cyc();
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_lock = 1'b0;
        next_cyc();
        mid();
        chk("relock_release", {63'd0, locked}, 64'd0);
        next_cyc();

        // Reset pulse right after a CPU read grant kills the pending return.
        cpu_req = 1'b1; cpu_addr = 32'h10;
        exp_gnt(1'b0, 1'b0, 32'h10, 32'h0);
        mid();
        next_cyc();
        cpu_req = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cpu_rq.delete();
        chk("rst_pulse_rvalid", {63'd0, cpu_rvalid}, 64'd0);
        chk("rst_pulse_rdata", {32'd0, cpu_rdata}, 64'd0);
        chk("rst_pulse_locked", {63'd0, locked}, 64'd0);
        mid();
        next_cyc();
        // Tie after reset: pointer favours the CPU again.
        cpu_req = 1'b1; cpu_addr = 32'h44; dbg_req = 1'b1; dbg_addr = 32'h48;
        exp_gnt(1'b0, 1'b0, 32'h44, 32'h0);
        mid();
        next_cyc();
        cpu_req = 1'b0;
        exp_gnt(1'b1, 1'b0, 32'h48, 32'h0);
        mid();
        next_cyc();
        dbg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            next_cyc();
        end

        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("cpu_rv_queue_drained", 64'(cpu_rq.size()), 64'd0);
        chk("dbg_rv_queue_drained", 64'(dbg_rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
